// File: rtl/tp_probe_mux.sv
// tp_probe_mux: test-point driver with group select, pulse stretch and trigger.
// Optional capture buffer built only when TP_CAPTURE_EN is defined.
module tp_probe_mux #(
    parameter int NGRP      = 8,
    parameter int TPW       = 16,
    parameter int STRETCH   = 4,
    parameter int CAP_DEPTH = 64
) (
    input  logic                    CLK,
    input  logic                    RST_B,
    input  logic [NGRP*TPW-1:0]     PROBES,
    input  logic                    SEL_WE,
    input  logic [$clog2(NGRP)-1:0] SEL_IN,
    input  logic [TPW-1:0]          STR_MASK,
    input  logic [$clog2(TPW)-1:0]  TRG_BIT,
    input  logic                    FREEZE,
    input  logic                    ARM,
    input  logic                    CAP_RD,
    output logic [TPW-1:0]          TP_OUT,
    output logic [$clog2(NGRP)-1:0] SEL_CUR,
    output logic                    SEL_ERR,
    output logic                    TRG_OUT,
    output logic [TPW-1:0]          CAP_DATA,
    output logic                    CAP_DONE,
    output logic                    CAP_EMPTY
);

    localparam int SW = $clog2(NGRP);
    localparam int CW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH - 1);

    logic [NGRP*TPW-1:0] p1_q;
    logic [SW-1:0]       sel_q;
    logic [TPW-1:0]      tp_q, tp_d;
    logic [TPW-1:0]      mprev_q, mprev_d;
    logic [TPW-1:0]      mux_w, edge_w, str_w;
    logic [CW-1:0]       cnt_q [TPW];
    logic [CW-1:0]       cnt_d [TPW];
    logic                err_q, err_d;
    logic                trg_q, trg_d;
    logic                sel_ok, sel_chg;

    // Select decode, stretch counters and next TP_OUT value
    always_comb begin
        sel_ok  = 32'(SEL_IN) < 32'(NGRP);
        sel_chg = SEL_WE && sel_ok && (SEL_IN != sel_q);
        err_d   = SEL_WE && !sel_ok;
        mux_w   = p1_q[sel_q*TPW +: TPW];
        edge_w  = mux_w & ~mprev_q;
        // After a switch, treat the new group as already high so a steady
        // bit does not look like an edge.
        mprev_d = sel_chg ? '1 : mux_w;
        trg_d   = edge_w[TRG_BIT] && !sel_chg;
        for (int i = 0; i < TPW; i++) begin
            cnt_d[i] = '0;
            str_w[i] = mux_w[i] | (STR_MASK[i] & (cnt_q[i] != '0));
            if (sel_chg) begin
                cnt_d[i] = '0;
            end else if (edge_w[i] && STR_MASK[i]) begin
                cnt_d[i] = CNT_LOAD;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        if (FREEZE) begin
            tp_d = tp_q;
        end else if (sel_chg) begin
            tp_d = '0;
        end else begin
            tp_d = str_w;
        end
    end

    // Probe pipeline, select register and per-bit stretch state
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            p1_q    <= '0;
            sel_q   <= '0;
            tp_q    <= '0;
            mprev_q <= '0;
            err_q   <= 1'b0;
            trg_q   <= 1'b0;
            for (int i = 0; i < TPW; i++) cnt_q[i] <= '0;
        end else begin
            p1_q    <= PROBES;
            tp_q    <= tp_d;
            mprev_q <= mprev_d;
            err_q   <= err_d;
            trg_q   <= trg_d;
            if (sel_chg) sel_q <= SEL_IN;
            for (int i = 0; i < TPW; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign TP_OUT  = tp_q;
    assign SEL_CUR = sel_q;
    assign SEL_ERR = err_q;
    assign TRG_OUT = trg_q;

`ifdef TP_CAPTURE_EN
    localparam int AW = $clog2(CAP_DEPTH);
    localparam logic [AW:0] N_LAST = (AW+1)'(CAP_DEPTH - 1);
    localparam logic [AW:0] N_ONE  = (AW+1)'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     st_q, st_d;
    logic [AW-1:0]  wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]    n_q, n_d;
    logic           we;
    logic [TPW-1:0] mem [CAP_DEPTH];

    // Capture FSM: arm, wait for trigger, fill, then drain by CAP_RD
    always_comb begin
        st_d = st_q;
        wp_d = wp_q;
        rp_d = rp_q;
        n_d  = n_q;
        we   = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                if (ARM) st_d = S_ARMED;
            end
            S_ARMED: begin
                if (sel_chg) begin
                    st_d = S_IDLE;
                    wp_d = '0;
                    rp_d = '0;
                    n_d  = '0;
                end else if (trg_q) begin
                    we   = 1'b1;
                    wp_d = wp_q + 1'b1;
                    n_d  = n_q + 1'b1;
                    st_d = S_FILL;
                end
            end
            S_FILL: begin
                if (sel_chg) begin
                    st_d = S_IDLE;
                    wp_d = '0;
                    rp_d = '0;
                    n_d  = '0;
                end else begin
                    we   = 1'b1;
                    wp_d = wp_q + 1'b1;
                    n_d  = n_q + 1'b1;
                    if (n_q == N_LAST) st_d = S_DONE;
                end
            end
            S_DONE: begin
                if (CAP_RD && n_q != '0) begin
                    rp_d = rp_q + 1'b1;
                    n_d  = n_q - 1'b1;
                    if (n_q == N_ONE) st_d = S_IDLE;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    // Capture state and pointers
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            st_q <= S_IDLE;
            wp_q <= '0;
            rp_q <= '0;
            n_q  <= '0;
        end else begin
            st_q <= st_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            n_q  <= n_d;
        end
    end

    // Sample storage records exactly what the pins show
    always_ff @(posedge CLK) begin
        if (we) mem[wp_q] <= tp_q;
    end

    assign CAP_DATA  = (n_q != '0) ? mem[rp_q] : '0;
    assign CAP_DONE  = (st_q == S_DONE);
    assign CAP_EMPTY = (n_q == '0);
`else
    logic unused_cap;
    assign unused_cap = ARM ^ CAP_RD ^ (CAP_DEPTH == 0);
    assign CAP_DATA   = '0;
    assign CAP_DONE   = 1'b0;
    assign CAP_EMPTY  = 1'b1;
`endif

endmodule
